// File: rtl/bin2bcd_seq_pkg.sv
// Shared FSM encoding and display constants for the sequential binary-to-BCD converter.
// Imported by the converter top; the digit-adjust cell is self-contained.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Digit code the display driver renders as "E" when the value is too large.
  localparam logic [3:0] DIGIT_ERR = 4'hE;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more, combinational.
// No state, no flow control; the 4-bit sum deliberately drops any carry.
module bcd_adj3 (
  input  logic [3:0] dig_i,
  output logic [3:0] dig_o
);

  assign dig_o = (dig_i >= 4'd5) ? (dig_i + 4'd3) : dig_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter; WIDTH+1 edges from accepted start to done.
// start is honoured only while idle (never queued); results hold until the next done or reset.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int DISP_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         bin,
  output logic                     busy,
  output logic                     done,
  output logic [4*DIGITS-1:0]      bcd,
  output logic [4*DISP_DIGITS-1:0] disp,
  output logic                     ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         sbin_q, sbin_d;
  logic [4*DIGITS-1:0]      sbcd_q, sbcd_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [4*DIGITS-1:0]      bcd_q, bcd_d;
  logic [4*DISP_DIGITS-1:0] disp_q, disp_d;
  logic                     ovf_q, ovf_d;

  logic [4*DIGITS-1:0]      sbcd_adj;
  logic [4*DIGITS-1:0]      sbcd_shift;
  logic [WIDTH-1:0]         sbin_shift;
  logic                     ovf_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .dig_i (sbcd_q[4*g +: 4]),
      .dig_o (sbcd_adj[4*g +: 4])
    );
  end

  // Adjusted digits and the binary word shift as one long register.
  assign sbcd_shift = {sbcd_adj[4*DIGITS-2:0], sbin_q[WIDTH-1]};
  assign sbin_shift = {sbin_q[WIDTH-2:0], 1'b0};
  assign ovf_next   = |(sbcd_shift >> (4*DISP_DIGITS));

  always_comb begin
    state_d = state_q;
    sbin_d  = sbin_q;
    sbcd_d  = sbcd_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sbin_d  = bin;
          sbcd_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy   = 1'b1;
        sbin_d = sbin_shift;
        sbcd_d = sbcd_shift;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          bcd_d   = sbcd_shift;
          ovf_d   = ovf_next;
          disp_d  = ovf_next ? {DISP_DIGITS{DIGIT_ERR}} : sbcd_shift[4*DISP_DIGITS-1:0];
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sbin_q  <= '0;
      sbcd_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sbin_q  <= sbin_d;
      sbcd_q  <= sbcd_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bcd  = bcd_q;
  assign disp = disp_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: random and corner values against a decimal reference model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bin = '0;
  logic        busy, done, ovf;
  logic [19:0] bcd;
  logic [15:0] disp;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .DISP_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .disp(disp), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    return v > 9999;
  endfunction

  function automatic logic [15:0] ref_disp(input int unsigned v);
    logic [19:0] r;
    r = ref_bcd(v);
    return ref_ovf(v) ? 16'hEEEE : r[15:0];
  endfunction

  // One conversion; bin is scrambled every cycle while busy. Sampling on negedges.
  task automatic run_conv(input logic [15:0] v, output logic [19:0] b, output logic [15:0] d,
                          output logic o, output int bcyc, output int ndone,
                          output int done_at, output int early_chg);
    logic [19:0] b0;
    b0 = bcd;
    b = 'x; d = 'x; o = 1'bx;
    bcyc = 0; ndone = 0; done_at = -1; early_chg = 0;
    @(negedge clk); start = 1'b1; bin = v;
    @(negedge clk); start = 1'b0; bin = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      if (busy) bcyc++;
      if (done) begin
        ndone++; done_at = bcyc; b = bcd; d = disp; o = ovf;
      end else if (ndone == 0 && bcd !== b0) begin
        early_chg++;
      end
      if (!busy) break;
      @(negedge clk); bin = 16'($urandom);
    end
  endtask

  task automatic test_reset;
    #1;
    chk_cnt++; if ({busy, done, ovf} !== 3'b000) $display("FAIL reset_ctl: got %b expected 000", {busy, done, ovf}); else pass_cnt++;
    chk_cnt++; if ({bcd, disp} !== 36'h0) $display("FAIL reset_data: got bcd=%h disp=%h expected 0", bcd, disp); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_zero;
    logic [19:0] b; logic [15:0] d; logic o; int bc, nd, da, ec;
    run_conv(16'd0, b, d, o, bc, nd, da, ec);
    chk_cnt++; if (nd !== 1 || da !== 17) $display("FAIL zero_done: got count=%0d at=%0d expected 1 at 17", nd, da); else pass_cnt++;
    chk_cnt++; if ({b, d, o} !== {20'h0, 16'h0, 1'b0}) $display("FAIL zero_result: got %h %h %b expected 0 0 0", b, d, o); else pass_cnt++;
  endtask

  task automatic test_1234;
    logic [19:0] b; logic [15:0] d; logic o; int bc, nd, da, ec;
    run_conv(16'd1234, b, d, o, bc, nd, da, ec);
    chk_cnt++; if (bc !== 17) $display("FAIL busy_len: got %0d expected 17", bc); else pass_cnt++;
    chk_cnt++; if (b !== 20'h01234 || d !== 16'h1234 || o !== 1'b0) $display("FAIL conv_1234: got %h %h %b expected 01234 1234 0", b, d, o); else pass_cnt++;
    chk_cnt++; if (ec !== 0) $display("FAIL hold_1234: got %0d early output changes expected 0", ec); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (bcd !== 20'h01234 || done !== 1'b0) $display("FAIL hold_idle: got bcd=%h done=%b expected 01234 0", bcd, done); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [19:0] b; logic [15:0] d; logic o; int bc, nd, da, ec;
    int unsigned v;
    for (int n = 0; n < 24; n++) begin
      v = (n < 4) ? ((n == 0) ? 9 : (n == 1) ? 10 : (n == 2) ? 9990 : 10001) : $urandom_range(0, 65535);
      run_conv(16'(v), b, d, o, bc, nd, da, ec);
      chk_cnt++;
      if (b !== ref_bcd(v) || d !== ref_disp(v) || o !== ref_ovf(v) || nd !== 1)
        $display("FAIL rand_%0d: got %h %h %b n=%0d expected %h %h %b", v, b, d, o, nd, ref_bcd(v), ref_disp(v), ref_ovf(v));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] r [2]; logic [15:0] dq [2]; logic oq [2];
    int nd, idle_gap;
    nd = 0; idle_gap = 0;
    @(negedge clk); start = 1'b1; bin = 16'd9999;
    @(negedge clk); bin = 16'd10000;
    for (int i = 0; i < 80 && nd < 2; i++) begin
      if (done) begin r[nd] = bcd; dq[nd] = disp; oq[nd] = ovf; nd++; end
      else if (!busy && nd == 1) idle_gap++;
      if (nd == 2) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk_cnt++; if (nd !== 2) $display("FAIL b2b_count: got %0d expected 2", nd); else pass_cnt++;
    chk_cnt++; if (idle_gap !== 1) $display("FAIL b2b_gap: got %0d expected 1", idle_gap); else pass_cnt++;
    chk_cnt++; if (r[0] !== 20'h09999 || oq[0] !== 1'b0 || dq[0] !== 16'h9999) $display("FAIL b2b_first: got %h %b expected 09999 0", r[0], oq[0]); else pass_cnt++;
    chk_cnt++; if (r[1] !== 20'h10000 || oq[1] !== 1'b1 || dq[1] !== 16'hEEEE) $display("FAIL b2b_second: got %h %b %h expected 10000 1 eeee", r[1], oq[1], dq[1]); else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_stop: got busy=%b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_max;
    logic [19:0] b; logic [15:0] d; logic o; int bc, nd, da, ec;
    run_conv(16'd65535, b, d, o, bc, nd, da, ec);
    chk_cnt++; if (b !== 20'h65535 || d !== 16'hEEEE || o !== 1'b1) $display("FAIL conv_max: got %h %h %b expected 65535 eeee 1", b, d, o); else pass_cnt++;
  endtask

  task automatic test_ignore_start;
    int nd; logic [19:0] b;
    nd = 0; b = 'x;
    @(negedge clk); start = 1'b1; bin = 16'd42;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (done) begin nd++; b = bcd; end
      start = (i == 4);
      bin = (i == 4) ? 16'd777 : 16'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk_cnt++; if (nd !== 1) $display("FAIL ignore_count: got %0d done pulses expected 1", nd); else pass_cnt++;
    chk_cnt++; if (b !== 20'h00042 || bcd !== 20'h00042) $display("FAIL ignore_value: got %h/%h expected 00042", b, bcd); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [19:0] b; logic [15:0] d; logic o; int bc, nd, da, ec;
    @(negedge clk); start = 1'b1; bin = 16'd500;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({busy, done, ovf} !== 3'b000) $display("FAIL arst_ctl: got %b expected 000", {busy, done, ovf}); else pass_cnt++;
    chk_cnt++; if (bcd !== 20'h0 || disp !== 16'h0) $display("FAIL arst_data: got %h %h expected 0 0", bcd, disp); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    run_conv(16'd500, b, d, o, bc, nd, da, ec);
    chk_cnt++; if (b !== 20'h00500 || d !== 16'h0500 || o !== 1'b0 || nd !== 1) $display("FAIL after_rst: got %h %h %b n=%0d expected 00500 0500 0 1", b, d, o, nd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_1234();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_max();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
